rr_select_arbiter: RTL and testbench
====================================

Name: rr_select_arbiter

Overview:
- Round-robin arbiter that generates the select index for the parameterized multiplexer sitting directly downstream of it.
- Chooses one of in_inputs requesters and drives sel and a one-hot gnt.
- Holds the choice stable under downstream backpressure using a valid/ready handshake.
- Returns a one-cycle ack to the requester whose word is consumed.

Parameters:
- in_inputs, 16, number of requesters (and number of mux inputs); legal range 1..256.
- log2ofin, derived, equals $clog2(in_inputs), forced to 1 when that is 0; width of sel, must match the mux.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  in_inputs  request per input; bit i means ins[i] holds a valid word.
- out_ready  input  1  downstream consumer accepts the mux output this cycle.
- sel  output  log2ofin  registered select index, driven to the mux sel.
- gnt  output  in_inputs  registered one-hot grant; equals 1 << sel when out_valid, else 0.
- out_valid  output  1  registered; mux output is valid this cycle.
- ack  output  in_inputs  combinational one-hot pulse: gnt when out_valid && out_ready, else 0.

Behaviour:
- Reset (asynchronous, rst_n low) values:
  - sel=0, gnt=0, out_valid=0, state=IDLE.
  - Internal last-served pointer = in_inputs-1, so index 0 has first priority.
  - Outputs take reset values immediately on rst_n assertion, not at the next edge.
- States:
  - IDLE: out_valid=0.
    - If any req bit is set, then at the next edge sel is loaded with the winner, gnt=1<<winner, out_valid=1, and the block moves to BUSY.
    - Latency is 1 cycle from req to out_valid.
  - BUSY: out_valid=1.
    - While out_ready=0, sel and gnt hold. Request withdrawal is ignored: the grant stays until the handshake.
    - Handshake cycle (out_valid && out_ready): ack=gnt, and the last-served pointer takes sel.
    - At the same edge, arbitrate again on the current req value. If any bit is set, load the new winner and stay in BUSY; otherwise clear out_valid and gnt, return to IDLE, and hold sel at its old value.
- Winner selection:
  - Search starts at index (pointer+1) mod in_inputs and wraps circularly; the first set req bit wins.
  - The just-served index is therefore lowest priority but is still granted if it is the only requester.
  - Throughput is one grant per cycle when out_ready stays 1.
- Width rules:
  - sel never takes a value of in_inputs or above, including for non-power-of-two in_inputs.
  - Wrap-around is computed modulo in_inputs, not modulo 2^log2ofin.
  - With in_inputs=1, sel is constant 0 and gnt/ack are 1 bit wide.
- Requester contract:
  - Keep req[i] asserted and ins[i] stable until ack[i].
  - Sample ack[i] to advance its data on the same edge.
- ack is purely combinational from registered state plus out_ready. It has no combinational path from req.

Test Plan:
- Reset and first grant (in_inputs=4): during reset check out_valid=0, sel=0, gnt=0. After release, drive req=4'b0100, out_ready=0; next cycle check sel=2, gnt=4'b0100, out_valid=1.
- Fairness under full load (in_inputs=4): req=4'b1111, out_ready=1 constant. Check sel sequence 0,1,2,3,0,1, one per cycle. Check ack is one-hot and matches gnt every cycle, and out_valid never drops.
- Backpressure and withdrawal (in_inputs=4): req=4'b0011, out_ready=0 for 3 cycles; sel=0 and gnt=4'b0001 must hold. Drop req[0] in cycle 2; sel must stay 0. Then out_ready=1: ack=4'b0001, and the next cycle sel=1.
- Single requester and idle return: req=4'b0010, out_ready=1 for 4 cycles. Check sel=1 and out_valid=1 every cycle. Then drop req; after the handshake edge out_valid=0 and gnt=0.
- Non-power-of-two wrap (in_inputs=5): serve index 4, then req=5'b00001. Check sel=0 next. Randomize req over 1000 cycles and check sel is never 5, 6 or 7.
- Async reset mid-grant: assert rst_n low while out_valid=1 and sel=3, between clock edges. Check all outputs go to reset values without waiting for an edge. After release with req=4'b1001, the first grant must be sel=0.

Source files
------------

// File: rtl/rr_select_arbiter.sv
// Round-robin select/grant generator for a downstream N:1 mux; 1-cycle req->out_valid latency.
// Grant holds under out_ready=0 regardless of req changes; one grant per cycle at full throughput.
module rr_select_arbiter #(
    parameter int in_inputs = 16,
    localparam int log2ofin = (in_inputs > 1) ? $clog2(in_inputs) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [in_inputs-1:0] req,
    input  logic                 out_ready,
    output logic [log2ofin-1:0]  sel,
    output logic [in_inputs-1:0] gnt,
    output logic                 out_valid,
    output logic [in_inputs-1:0] ack
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state, state_nxt;
    logic [log2ofin-1:0]   ptr, ptr_nxt, sel_nxt, base, winner;
    logic [in_inputs-1:0]  gnt_nxt, win_oh, hi_oh, lo_oh;
    logic [log2ofin-1:0]   hi_idx, lo_idx;
    logic                  hi_found, any_req;

    assign any_req   = |req;
    assign out_valid = (state == BUSY);
    assign ack       = (out_valid && out_ready) ? gnt : '0;

    // On a handshake the index being served becomes the new pointer, so search from it.
    assign base = (state == BUSY) ? sel : ptr;

    // Lowest requester strictly above base wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_oh    = '0;
        lo_oh    = '0;
        hi_found = 1'b0;
        for (int i = in_inputs - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx   = log2ofin'(i);
                lo_oh    = '0;
                lo_oh[i] = 1'b1;
                if (i > int'(base)) begin
                    hi_idx   = log2ofin'(i);
                    hi_oh    = '0;
                    hi_oh[i] = 1'b1;
                    hi_found = 1'b1;
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
        win_oh = hi_found ? hi_oh : lo_oh;
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (any_req) begin
                    sel_nxt   = winner;
                    gnt_nxt   = win_oh;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    ptr_nxt = sel;
                    if (any_req) begin
                        sel_nxt = winner;
                        gnt_nxt = win_oh;
                    end else begin
                        gnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            gnt   <= '0;
            ptr   <= log2ofin'(in_inputs - 1);
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed bench for rr_select_arbiter with 4-input and 5-input instances sharing clock and reset.
module tb_rr_select_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req4;
    logic       rdy4;
    logic [1:0] sel4;
    logic [3:0] gnt4;
    logic       vld4;
    logic [3:0] ack4;
    logic [4:0] req5;
    logic       rdy5;
    logic [2:0] sel5;
    logic [4:0] gnt5;
    logic       vld5;
    logic [4:0] ack5;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    rr_select_arbiter #(.in_inputs(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .out_ready(rdy4),
        .sel(sel4), .gnt(gnt4), .out_valid(vld4), .ack(ack4)
    );

    rr_select_arbiter #(.in_inputs(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .out_ready(rdy5),
        .sel(sel5), .gnt(gnt5), .out_valid(vld5), .ack(ack5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        logic [4:0] exp_oh;

        rst_n = 1'b0;
        req4  = '0;
        rdy4  = 1'b0;
        req5  = '0;
        rdy5  = 1'b0;

        // Reset state and first grant
        #12;
        chk("rst_vld", 32'(vld4), 32'd0);
        chk("rst_sel", 32'(sel4), 32'd0);
        chk("rst_gnt", 32'(gnt4), 32'd0);
        rst_n = 1'b1;
        req4  = 4'b0100;
        rdy4  = 1'b0;
        step();
        chk("first_sel", 32'(sel4), 32'd2);
        chk("first_gnt", 32'(gnt4), 32'b0100);
        chk("first_vld", 32'(vld4), 32'd1);

        // Fairness under full load
        pulse_reset();
        req4 = 4'b1111;
        rdy4 = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("fair_sel", 32'(sel4), 32'(seq[i]));
            chk("fair_gnt", 32'(gnt4), 32'(1) << seq[i]);
            chk("fair_ack", 32'(ack4), 32'(1) << seq[i]);
            chk("fair_vld", 32'(vld4), 32'd1);
            step();
        end

        // Backpressure with request withdrawal
        pulse_reset();
        req4 = 4'b0011;
        rdy4 = 1'b0;
        step();
        chk("bp_sel0", 32'(sel4), 32'd0);
        chk("bp_gnt0", 32'(gnt4), 32'b0001);
        chk("bp_ack0", 32'(ack4), 32'd0);
        step();
        chk("bp_sel1", 32'(sel4), 32'd0);
        req4 = 4'b0010;
        step();
        chk("bp_sel2", 32'(sel4), 32'd0);
        chk("bp_gnt2", 32'(gnt4), 32'b0001);
        chk("bp_vld2", 32'(vld4), 32'd1);
        rdy4 = 1'b1;
        #1;
        chk("bp_ack", 32'(ack4), 32'b0001);
        step();
        chk("bp_next_sel", 32'(sel4), 32'd1);

        // Single requester then idle return
        for (int i = 0; i < 4; i++) begin
            chk("single_sel", 32'(sel4), 32'd1);
            chk("single_vld", 32'(vld4), 32'd1);
            chk("single_ack", 32'(ack4), 32'b0010);
            step();
        end
        req4 = 4'b0000;
        step();
        chk("idle_vld", 32'(vld4), 32'd0);
        chk("idle_gnt", 32'(gnt4), 32'd0);
        chk("idle_sel", 32'(sel4), 32'd1);
        chk("idle_ack", 32'(ack4), 32'd0);

        // Non-power-of-two wrap
        pulse_reset();
        req5 = 5'b10000;
        rdy5 = 1'b1;
        step();
        chk("w5_sel4", 32'(sel5), 32'd4);
        req5 = 5'b00001;
        #1;
        chk("w5_ack4", 32'(ack5), 32'b10000);
        step();
        chk("w5_wrap_sel", 32'(sel5), 32'd0);
        chk("w5_wrap_gnt", 32'(gnt5), 32'b00001);
        for (int i = 0; i < 1000; i++) begin
            req5 = 5'($urandom_range(0, 31));
            rdy5 = 1'($urandom_range(0, 1));
            step();
            chk("w5_sel_range", 32'(sel5 < 3'd5), 32'd1);
            exp_oh = vld5 ? (5'b00001 << sel5) : 5'b00000;
            chk("w5_gnt_onehot", 32'(gnt5), 32'(exp_oh));
        end

        // Asynchronous reset mid-grant
        pulse_reset();
        req4 = 4'b1000;
        rdy4 = 1'b0;
        step();
        chk("ar_pre_sel", 32'(sel4), 32'd3);
        chk("ar_pre_vld", 32'(vld4), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_vld", 32'(vld4), 32'd0);
        chk("ar_sel", 32'(sel4), 32'd0);
        chk("ar_gnt", 32'(gnt4), 32'd0);
        chk("ar_ack", 32'(ack4), 32'd0);
        req4 = 4'b1001;
        #1;
        rst_n = 1'b1;
        step();
        chk("ar_first_sel", 32'(sel4), 32'd0);
        chk("ar_first_gnt", 32'(gnt4), 32'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
